axi4_lite_slave_if: RTL and testbench

Parametrised AXI4-Lite slave front end.
- Translates AXI4-Lite write and read transactions into the team's simple register-bank handshake (addr/en/data/strb/ack).
- Successor to the fixed 32-bit, 16-register interface: generic data width and register count.
- New over the 16-register interface: independent AW/W capture in either order, address range check, and an ack timeout that returns SLVERR instead of hanging the bus.

---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_ack_timer.sv | 30 +++
 rtl/axi4_lite_slave_if.sv | 215 +++++++++++++++++++++
 tb/tb_axi4_lite_slave_if.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared constants for the AXI4-Lite slave front end: response codes and
// FSM state encodings.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_EXEC = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_EXEC = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

endpackage

// File: rtl/axi4_lite_ack_timer.sv
// Ack wait counter: cleared outside EXEC, counts EXEC cycles, flags the last
// cycle in which an ack is still accepted.
module axi4_lite_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Count reaches ACK_TIMEOUT at the end of this cycle unless ack arrives.
  assign expired = en && (cnt == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite slave front end translating AXI transactions into the simple
// register-bank addr/en/data/strb/ack handshake.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order)
// W_EXEC | wr_en held, waiting for wr_ack or timeout
// W_RESP | bvalid held until bready
// R_IDLE | arready high, waiting for AR
// R_EXEC | rd_en held, waiting for rd_ack or timeout
// R_RESP | rvalid held until rready
module axi4_lite_slave_if
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 32,
  parameter int NUM_REGS    = 16,
  parameter int ACK_TIMEOUT = 15,
  localparam int STRB_BITS  = DATA_BITS / 8,
  localparam int REG_BITS   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [DATA_BITS-1:0] s_axi_wdata,
  input  logic [STRB_BITS-1:0] s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDR_BITS-1:0] s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [DATA_BITS-1:0] s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [REG_BITS-1:0]  wr_addr,
  output logic                 wr_en,
  output logic [DATA_BITS-1:0] wr_data,
  output logic [STRB_BITS-1:0] wr_strb,
  input  logic                 wr_ack,
  output logic [REG_BITS-1:0]  rd_addr,
  output logic                 rd_en,
  input  logic [DATA_BITS-1:0] rd_data,
  input  logic                 rd_ack
);

  localparam int LSB   = $clog2(STRB_BITS);
  localparam int IDX_W = ADDR_BITS - LSB;
  localparam logic [IDX_W:0] NUM_REGS_X = (IDX_W + 1)'(NUM_REGS);

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NUM_REGS_X;
  endfunction

  logic                 run;
  logic [1:0]           w_state, r_state;
  logic                 aw_held, w_held, aw_ok;
  logic [REG_BITS-1:0]  w_idx, r_idx;
  logic [DATA_BITS-1:0] w_data_q, rdata_q;
  logic [STRB_BITS-1:0] w_strb_q;
  logic [1:0]           bresp_q, rresp_q;
  logic                 w_expired, r_expired;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_hs, w_hs, ar_hs, w_both, w_ok_next;
  logic             unused_addr_lsbs;

  assign aw_idx    = s_axi_awaddr[ADDR_BITS-1:LSB];
  assign ar_idx    = s_axi_araddr[ADDR_BITS-1:LSB];
  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign ar_hs     = s_axi_arvalid & s_axi_arready;
  assign w_both    = (aw_held | aw_hs) & (w_held | w_hs);
  assign w_ok_next = aw_hs ? idx_ok(aw_idx) : aw_ok;
  assign unused_addr_lsbs = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  // Keeps the ready outputs low while rst is asserted and for the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run <= 1'b0;
    else     run <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_ok    <= 1'b0;
      w_idx    <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            aw_ok   <= idx_ok(aw_idx);
            w_idx   <= aw_idx[REG_BITS-1:0];
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
          end
          if (w_both) begin
            if (w_ok_next) begin
              w_state <= W_EXEC;
            end else begin
              bresp_q <= RESP_SLVERR;
              w_state <= W_RESP;
            end
          end
        end
        W_EXEC: begin
          if (wr_ack) begin
            bresp_q <= RESP_OKAY;
            w_state <= W_RESP;
          end else if (w_expired) begin
            bresp_q <= RESP_SLVERR;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: begin
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx <= ar_idx[REG_BITS-1:0];
            if (idx_ok(ar_idx)) begin
              r_state <= R_EXEC;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
              r_state <= R_RESP;
            end
          end
        end
        R_EXEC: begin
          if (rd_ack) begin
            rdata_q <= rd_data;
            rresp_q <= RESP_OKAY;
            r_state <= R_RESP;
          end else if (r_expired) begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi4_lite_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wr_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_state != W_EXEC),
    .en      (w_state == W_EXEC),
    .expired (w_expired)
  );

  axi4_lite_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_rd_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (r_state != R_EXEC),
    .en      (r_state == R_EXEC),
    .expired (r_expired)
  );

  assign s_axi_awready = run && (w_state == W_IDLE) && !aw_held;
  assign s_axi_wready  = run && (w_state == W_IDLE) && !w_held;
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = run && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign wr_en   = (w_state == W_EXEC);
  assign wr_addr = w_idx;
  assign wr_data = w_data_q;
  assign wr_strb = w_strb_q;
  assign rd_en   = (r_state == R_EXEC);
  assign rd_addr = r_idx;

endmodule

// File: tb/tb_axi4_lite_slave_if.sv
// Scoreboard bench for axi4_lite_slave_if: a behavioural register bank acks
// wr_en/rd_en, expected bank accesses and AXI responses are queued at issue.
module tb_axi4_lite_slave_if;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          cycles;
  } wr_exp_t;

  typedef struct {
    logic [3:0] addr;
    int         cycles;
  } rd_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  wr_addr, rd_addr, wr_strb;
  logic        wr_en, rd_en;
  logic [31:0] wr_data;
  logic        wr_ack = 1'b0, rd_ack = 1'b0;
  logic [31:0] rd_value = 32'h1111_2222;

  int n_checks = 0;
  int n_errors = 0;
  int wr_ack_after = 1, rd_ack_after = 1;
  int b_stall = 0, r_stall = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

  wr_exp_t     exp_wr[$];
  rd_exp_t     exp_rd[$];
  logic [1:0]  exp_b[$];
  r_exp_t      exp_r[$];

  always #5 clk = ~clk;

  axi4_lite_slave_if dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .wr_addr       (wr_addr),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_ack        (wr_ack),
    .rd_addr       (rd_addr),
    .rd_en         (rd_en),
    .rd_data       (rd_value),
    .rd_ack        (rd_ack)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
  end

  // Register bank model: acks after a programmed number of strobe cycles.
  initial begin
    int wr_cyc, rd_cyc;
    wr_exp_t we;
    rd_exp_t re;
    wr_cyc = 0;
    rd_cyc = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        wr_cyc = 0; rd_cyc = 0; wr_ack = 1'b0; rd_ack = 1'b0;
      end else begin
        if (wr_en) begin
          wr_cyc++;
          if (wr_cyc == 1) begin
            check("wr_en_expected", exp_wr.size() != 0, 1'b1);
            if (exp_wr.size() != 0) begin
              check("wr_addr", wr_addr, exp_wr[0].addr);
              check("wr_data", wr_data, exp_wr[0].data);
              check("wr_strb", wr_strb, exp_wr[0].strb);
            end
          end
          wr_ack = (wr_cyc == wr_ack_after);
        end else begin
          wr_ack = 1'b0;
          if (wr_cyc > 0) begin
            if (exp_wr.size() != 0) begin
              we = exp_wr.pop_front();
              check("wr_en_cycles", wr_cyc, we.cycles);
            end
            wr_cyc = 0;
          end
        end
        if (rd_en) begin
          rd_cyc++;
          if (rd_cyc == 1) begin
            check("rd_en_expected", exp_rd.size() != 0, 1'b1);
            if (exp_rd.size() != 0) check("rd_addr", rd_addr, exp_rd[0].addr);
          end
          rd_ack = (rd_cyc == rd_ack_after);
        end else begin
          rd_ack = 1'b0;
          if (rd_cyc > 0) begin
            if (exp_rd.size() != 0) begin
              re = exp_rd.pop_front();
              check("rd_en_cycles", rd_cyc, re.cycles);
            end
            rd_cyc = 0;
          end
        end
      end
    end
  end

  // B channel: hold bready low for b_stall cycles, check bresp every valid cycle.
  initial begin
    int bcyc;
    bcyc = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bvalid) begin
        bready = 1'b0; bcyc = 0;
      end else begin
        bcyc++;
        if (bcyc == 1) check("b_expected", exp_b.size() != 0, 1'b1);
        if (exp_b.size() != 0) check("bresp", bresp, exp_b[0]);
        if (bcyc > b_stall) begin
          bready = 1'b1;
          if (exp_b.size() != 0) void'(exp_b.pop_front());
        end
      end
    end
  end

  // R channel: same scheme; repeated checks catch rdata/rresp instability.
  initial begin
    int rcyc;
    rcyc = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !rvalid) begin
        rready = 1'b0; rcyc = 0;
      end else begin
        rcyc++;
        if (rcyc == 1) check("r_expected", exp_r.size() != 0, 1'b1);
        if (exp_r.size() != 0) begin
          check("rdata", rdata, exp_r[0].data);
          check("rresp", rresp, exp_r[0].resp);
        end
        if (rcyc > r_stall) begin
          rready = 1'b1;
          if (exp_r.size() != 0) void'(exp_r.pop_front());
        end
      end
    end
  end

  task automatic send_aw(input logic [7:0] a);
    logic ok;
    ok = 1'b0;
    awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    check("aw_handshake", ok, 1'b1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = wready;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    check("w_handshake", ok, 1'b1);
  endtask

  task automatic send_ar(input logic [7:0] a);
    logic ok;
    ok = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    check("ar_handshake", ok, 1'b1);
  endtask

  function automatic logic ack_in_time(input int ack_after);
    return ack_after >= 1 && ack_after <= 15;
  endfunction

  // order 0: AW then W two cycles later; 1: W then AW; 2: same cycle.
  task automatic issue_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int ack_after, input int order);
    int idx;
    idx = int'(a) >> 2;
    if (idx < 16) begin
      exp_wr.push_back('{addr: 4'(idx), data: d, strb: s,
                         cycles: ack_in_time(ack_after) ? ack_after : 15});
      exp_b.push_back(ack_in_time(ack_after) ? 2'b00 : 2'b10);
    end else begin
      exp_b.push_back(2'b10);
    end
    wr_ack_after = ack_after;
    fork
      begin
        if (order == 1) repeat (2) begin @(posedge clk); #1; end
        send_aw(a);
      end
      begin
        if (order == 0) repeat (2) begin @(posedge clk); #1; end
        send_w(d, s);
      end
    join
  endtask

  task automatic issue_read(input logic [7:0] a, input int ack_after);
    int idx;
    idx = int'(a) >> 2;
    if (idx < 16) begin
      exp_rd.push_back('{addr: 4'(idx), cycles: ack_in_time(ack_after) ? ack_after : 15});
      exp_r.push_back('{data: ack_in_time(ack_after) ? rd_value : 32'h0,
                        resp: ack_in_time(ack_after) ? 2'b00 : 2'b10});
    end else begin
      exp_r.push_back('{data: 32'h0, resp: 2'b10});
    end
    rd_ack_after = ack_after;
    send_ar(a);
  endtask

  task automatic wait_drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      done = exp_wr.size() == 0 && exp_rd.size() == 0 && exp_b.size() == 0 &&
             exp_r.size() == 0 && !wr_en && !rd_en && !bvalid && !rvalid;
      if (!done) begin @(posedge clk); #1; end
    end
    check(tag, done, 1'b1);
  endtask

  task automatic write_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int ack_after, input int order);
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    issue_write(a, d, s, ack_after, order);
    wait_drain("write_drain");
    check("aw_once", aw_cnt - aw0, 1);
    check("w_once", w_cnt - w0, 1);
  endtask

  task automatic read_txn(input logic [7:0] a, input int ack_after);
    int ar0;
    ar0 = ar_cnt;
    issue_read(a, ack_after);
    wait_drain("read_drain");
    check("ar_once", ar_cnt - ar0, 1);
  endtask

  function automatic logic [127:0] all_outputs();
    return {awready, wready, arready, bvalid, rvalid, wr_en, rd_en, bresp, rresp,
            wr_addr, rd_addr, wr_strb, wr_data, rdata};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {awready, wready, arready}, 3'b111);

    b_stall = 2;
    write_txn(8'h0C, 32'h1234_5678, 4'hF, 2, 0);
    b_stall = 0;
    write_txn(8'h0C, 32'h1234_5678, 4'hF, 1, 1);
    write_txn(8'h0C, 32'h1234_5678, 4'hF, 1, 2);
    write_txn(8'h28, 32'hCAFE_0042, 4'b0101, 1, 2);

    write_txn(8'h40, 32'hFFFF_FFFF, 4'hF, 1, 2);
    rd_value = 32'h5A5A_A5A5;
    read_txn(8'h40, 1);

    rd_value = 32'hA5A5_0001;
    read_txn(8'h1C, 0);
    read_txn(8'h1C, 15);
    write_txn(8'h3C, 32'h0000_00FF, 4'h1, 0, 0);
    write_txn(8'h3C, 32'h0000_00FF, 4'h1, 15, 0);

    rd_value = 32'hDEAD_BEEF;
    r_stall = 4;
    fork
      issue_read(8'h14, 1);
      issue_write(8'h24, 32'h0BAD_CAFE, 4'hC, 3, 2);
    join
    wait_drain("concurrent_drain");
    r_stall = 0;

    issue_write(8'h08, 32'h7777_7777, 4'hF, 0, 2);
    for (int i = 0; i < 20 && !wr_en; i++) begin @(posedge clk); #1; end
    check("wr_en_before_reset", wr_en, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_exec_reset_outputs", all_outputs(), '0);
    exp_wr.delete(); exp_b.delete(); exp_rd.delete(); exp_r.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    write_txn(8'h18, 32'h3141_5926, 4'hF, 1, 0);
    rd_value = 32'h0BAD_F00D;
    read_txn(8'h08, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
